// File: rtl/counter_sampler.sv
// counter_sampler: periodically reads a counter over the host bus and reports each sample and its delta
module counter_sampler #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddressWidth = 32,
    parameter logic [AddressWidth-1:0] TargetAddr = 'h40000,
    parameter int unsigned PeriodWidth = 16,
    parameter int unsigned TimeoutCycles = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [PeriodWidth-1:0]  period_i,
    output logic                    host_req_o,
    input  logic                    host_gnt_i,
    output logic [AddressWidth-1:0] host_addr_o,
    output logic                    host_we_o,
    output logic [DataWidth/8-1:0]  host_be_o,
    output logic [DataWidth-1:0]    host_wdata_o,
    input  logic                    host_rvalid_i,
    input  logic [DataWidth-1:0]    host_rdata_i,
    input  logic                    host_err_i,
    output logic                    sample_valid_o,
    output logic [DataWidth-1:0]    sample_data_o,
    output logic [DataWidth-1:0]    sample_delta_o,
    output logic                    sample_err_o,
    output logic                    sample_timeout_o,
    output logic                    busy_o
);
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, WAIT} state_e;

    state_e                 state_q, state_d;
    logic                   first_q, first_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   tmo_q, tmo_d;
    logic [DataWidth-1:0]   prev_q, prev_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [DataWidth-1:0]   delta_q, delta_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [PeriodWidth-1:0] wcnt_q, wcnt_d;
    logic                   done;

    if (DataWidth != 32 || TimeoutCycles == 0) begin : g_param_check
        $error("counter_sampler: DataWidth must be 32 and TimeoutCycles at least 1");
    end

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        valid_d = 1'b0;
        err_d   = err_q;
        tmo_d   = tmo_q;
        prev_d  = prev_q;
        data_d  = data_q;
        delta_d = delta_q;
        tcnt_d  = tcnt_q;
        wcnt_d  = wcnt_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = en_i ? REQ : IDLE;
                first_d = en_i | first_q;
            end
            REQ: begin
                state_d = host_gnt_i ? RESP : REQ;
                tcnt_d  = '0;
            end
            RESP: begin
                tcnt_d = tcnt_q + 1'b1;
                done   = host_rvalid_i || tcnt_q == TW'(TimeoutCycles - 1);
                if (host_rvalid_i && !host_err_i) begin
                    data_d  = host_rdata_i;
                    delta_d = first_q ? '0 : host_rdata_i - prev_q;
                    prev_d  = host_rdata_i;
                    first_d = 1'b0;
                end
                if (done) begin
                    valid_d = 1'b1;
                    err_d   = host_rvalid_i & host_err_i;
                    tmo_d   = !host_rvalid_i;
                    state_d = !en_i ? IDLE : (period_i == '0 ? REQ : WAIT);
                    wcnt_d  = period_i - 1'b1;
                end
            end
            WAIT: begin
                wcnt_d  = wcnt_q - 1'b1;
                state_d = !en_i ? IDLE : (wcnt_q == '0 ? REQ : WAIT);
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            first_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            prev_q  <= '0;
            data_q  <= '0;
            delta_q <= '0;
            tcnt_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            prev_q  <= prev_d;
            data_q  <= data_d;
            delta_q <= delta_d;
            tcnt_q  <= tcnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign host_req_o       = state_q == REQ;
    assign host_addr_o      = host_req_o ? TargetAddr : '0;
    assign host_we_o        = 1'b0;
    assign host_be_o        = '1;
    assign host_wdata_o     = '0;
    assign sample_valid_o   = valid_q;
    assign sample_data_o    = data_q;
    assign sample_delta_o   = delta_q;
    assign sample_err_o     = err_q;
    assign sample_timeout_o = tmo_q;
    assign busy_o           = state_q != IDLE;
endmodule
